instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Write-side counterpart to instruction fetch. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into the 16-entry instruction memory. It exposes the combinational read port that the fetch stage indexes with its PC, so programs are loaded at run time instead of being preloaded at elaboration. Sits between the program-load source (debug/boot link) and the fetch stage.

## Interface

Parameters:
- DEPTH, 16, number of instruction words
- ADDR_W, 4, log2(DEPTH)
- DATA_W, 32, instruction width (fixed at 4 bytes)

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begin (or restart) a load
- num_words  in  ADDR_W+1  words to load, sampled on start; values >DEPTH clamp to DEPTH
- byte_valid  in  1  source has a byte
- byte_data  in  8  byte payload
- byte_ready  out  1  loader accepts a byte this cycle
- fetch_addr  in  ADDR_W  read address from fetch stage
- fetch_data  out  DATA_W  mem[fetch_addr], combinational
- load_busy  out  1  high in LOAD
- load_done  out  1  high in DONE
- word_count  out  ADDR_W+1  words written in current/last load

## Operation

- States: IDLE, LOAD, DONE. Reset -> IDLE.
- Reset values: byte_ready=0, load_busy=0, load_done=0, word_count=0, byte counter=0, word address=0, all memory words=0 (so fetch_data=0).
- IDLE: byte_ready=0. start -> latch target=min(num_words,DEPTH); if target==0 -> DONE, else -> LOAD.
- LOAD: byte_ready=1. Handshake = byte_valid & byte_ready. Byte k (k=0..3 within word) goes to bits [8k+7:8k]. On the handshake of byte 3, mem[word_addr] <= {b3,b2,b1,b0} (the edge that accepts b3 also writes), word_addr++, word_count++, byte counter -> 0. If word_count+1==target -> DONE on that same edge.
- byte_valid low in LOAD: nothing changes; no timeout.
- DONE: byte_ready=0, load_done=1. Memory holds. start -> new load exactly as from IDLE.
- start in LOAD: abort and restart; partial-word bytes discarded, already written words retained, counters cleared, target re-latched. start has priority over a same-cycle handshake (that byte is dropped).
- resetn low at any time (including mid-word): immediate return to IDLE with reset values, memory cleared.
- Read port: fetch_data reflects memory contents only; a write to the addressed word appears on fetch_data the cycle after the writing edge. Reads are legal in every state.
- Word address never exceeds DEPTH-1 (guaranteed by clamp); no wrap.

## Timing

- byte_ready rises the cycle after start.
- Minimum load time for N words: 4N handshake cycles; load_done high the cycle after the final handshake edge; load_busy falls simultaneously.
- word_count is registered, updates on the edge writing each word.
- fetch_data: zero-cycle combinational path from fetch_addr.

## Structure

- Shared package: DEPTH, ADDR_W, DATA_W constants; state enum {IDLE, LOAD, DONE}.
- Sub-module instr_mem_array: DEPTH x DATA_W register file, one synchronous write port (we, waddr, wdata), one asynchronous read port, asynchronous clear on resetn. Loader holds FSM, byte counter, word assembly register.

## Test plan

- Reset then start with num_words=2, stream bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 back-to-back -> mem[0]=0x00000013, mem[1]=0x00100093, load_done high 1 cycle after 8th handshake, word_count=2.
- Same load with byte_valid toggling every other cycle -> identical memory contents, byte_ready stays high in LOAD, bytes only consumed on handshake.
- num_words=20 with 64 bytes -> exactly 16 words written, DONE after 64th byte, byte_ready=0 thereafter.
- start pulse after 6 bytes of a 3-word load -> mem[0] keeps word 0, 2 partial bytes dropped, next 4 bytes land in mem[0] again, word_count restarts at 0.
- resetn asserted after 5 bytes -> all outputs at reset values immediately, fetch_data=0 for every fetch_addr.
- start with num_words=0 -> DONE next cycle, byte_ready never asserted, memory unchanged.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants, state encoding and the word-count clamp for the instruction
// memory loader.
package instr_mem_loader_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Requested lengths beyond the memory size are limited to a full fill.
    function automatic logic [ADDR_W:0] clamp_words(input logic [ADDR_W:0] n);
        logic [ADDR_W:0] depth_w;
        depth_w = (ADDR_W + 1)'(DEPTH);
        if (n > depth_w) begin
            return depth_w;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream valid/ready handshake from the program-load source to the loader.
interface instr_mem_loader_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);

endinterface

// File: rtl/instr_mem_loader_mem_array.sv
// Instruction register file: one synchronous write port, one combinational read
// port, cleared asynchronously by resetn.
module instr_mem_array
    import instr_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next memory image: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage update with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Assembles little-endian 32-bit words from a byte stream and writes them
// sequentially into the instruction memory; exposes the fetch read port.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W:0]     num_words,
    instr_mem_loader_if.slave   bus,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic [DATA_W-1:0]   fetch_data,
    output logic                load_busy,
    output logic                load_done,
    output logic [ADDR_W:0]     word_count
);

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W:0]   target_q, target_d;
    logic              byte_ready_q, byte_ready_d;
    logic              load_busy_q, load_busy_d;
    logic              load_done_q, load_done_d;
    logic              we_s;
    logic [DATA_W-1:0] wdata_s;
    logic [ADDR_W:0]   tgt_s;
    logic              hs_s;

    assign tgt_s   = clamp_words(num_words);
    assign hs_s    = bus.byte_valid & byte_ready_q;
    assign wdata_s = {bus.byte_data, asm_q};

    // Next state, counters, word assembly and write strobe.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        word_addr_d  = word_addr_q;
        word_count_d = word_count_q;
        target_d     = target_q;
        we_s         = 1'b0;
        if (start) begin
            // A restart wins over any same-cycle byte and drops the partial word.
            target_d     = tgt_s;
            word_count_d = '0;
            word_addr_d  = '0;
            byte_cnt_d   = 2'd0;
            asm_d        = 24'd0;
            state_d      = (tgt_s == '0) ? DONE : LOAD;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    if (hs_s) begin
                        case (byte_cnt_q)
                            2'd0: asm_d[7:0]   = bus.byte_data;
                            2'd1: asm_d[15:8]  = bus.byte_data;
                            2'd2: asm_d[23:16] = bus.byte_data;
                            2'd3: begin
                                we_s         = 1'b1;
                                word_count_d = word_count_q + (ADDR_W + 1)'(1);
                                if (word_count_d == target_q) begin
                                    state_d = DONE;
                                end else begin
                                    word_addr_d = word_addr_q + ADDR_W'(1);
                                end
                            end
                            default: asm_d = asm_q;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end else begin
                        state_d = LOAD;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
        byte_ready_d = (state_d == LOAD);
        load_busy_d  = (state_d == LOAD);
        load_done_d  = (state_d == DONE);
    end

    // Loader state and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 24'd0;
            word_addr_q  <= '0;
            word_count_q <= '0;
            target_q     <= '0;
            byte_ready_q <= 1'b0;
            load_busy_q  <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            word_addr_q  <= word_addr_d;
            word_count_q <= word_count_d;
            target_q     <= target_d;
            byte_ready_q <= byte_ready_d;
            load_busy_q  <= load_busy_d;
            load_done_q  <= load_done_d;
        end
    end

    instr_mem_array u_mem (
        .clk    (clk),
        .resetn (resetn),
        .we     (we_s),
        .waddr  (word_addr_q),
        .wdata  (wdata_s),
        .raddr  (fetch_addr),
        .rdata  (fetch_data)
    );

    assign bus.byte_ready = byte_ready_q;
    assign load_busy      = load_busy_q;
    assign load_done      = load_done_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized byte-stream loads checked against a queue-based model
// of the loaded program image.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              load_busy;
    logic              load_done;
    logic [ADDR_W:0]   word_count;

    instr_mem_loader_if bs ();

    instr_mem_loader dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .num_words  (num_words),
        .bus        (bs),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] m_mem [16];
    bit          m_busy;
    bit          m_done;
    int          m_count;
    int          m_target;
    logic [7:0]  m_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_count = 0;
        m_target = 0;
        m_q.delete();
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".byte_ready"}, {31'd0, bs.byte_ready}, {31'd0, m_busy});
        chk({tag, ".load_busy"},  {31'd0, load_busy},     {31'd0, m_busy});
        chk({tag, ".load_done"},  {31'd0, load_done},     {31'd0, m_done});
        chk({tag, ".word_count"}, {27'd0, word_count},    m_count);
    endtask

    // One clock: drive at negedge, update the model at the edge, check after it.
    task automatic step(input logic st, input int nw, input logic v, input logic [7:0] d);
        int fa;
        @(negedge clk);
        start = st;
        num_words = nw[4:0];
        bs.byte_valid = v;
        bs.byte_data = d;
        @(posedge clk);
        if (st) begin
            m_target = (nw > 16) ? 16 : nw;
            m_count = 0;
            m_q.delete();
            m_busy = (m_target != 0);
            m_done = (m_target == 0);
        end else if (m_busy && v) begin
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                m_mem[m_count] = {m_q[3], m_q[2], m_q[1], m_q[0]};
                m_count++;
                m_q.delete();
                if (m_count == m_target) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        #1;
        fa = $urandom_range(0, 15);
        fetch_addr = fa[3:0];
        #1;
        chk_status("step");
        chk("step.fetch_data", fetch_data, m_mem[fa]);
    endtask

    task automatic quiet_inputs();
        @(negedge clk);
        start = 1'b0;
        bs.byte_valid = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        quiet_inputs();
        for (int a = 0; a < 16; a++) begin
            fetch_addr = a[3:0];
            #1;
            chk({tag, ".mem"}, fetch_data, m_mem[a]);
        end
    endtask

    task automatic apply_reset(input string tag);
        quiet_inputs();
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        chk_status(tag);
        for (int a = 0; a < 16; a++) begin
            fetch_addr = a[3:0];
            #1;
            chk({tag, ".fetch_zero"}, fetch_data, 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [7:0] prog [8];
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        resetn = 1'b0;
        start = 1'b0;
        num_words = '0;
        bs.byte_valid = 1'b0;
        bs.byte_data = 8'd0;
        fetch_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_status("por");
        chk("por.fetch_data", fetch_data, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Two-word program, back-to-back bytes.
        step(1'b1, 2, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, prog[i]);
        step(1'b0, 0, 1'b1, 8'hAA);
        step(1'b0, 0, 1'b0, 8'h00);
        fetch_addr = 4'd0;
        #1;
        chk("t1.word0", fetch_data, 32'h0000_0013);
        fetch_addr = 4'd1;
        #1;
        chk("t1.word1", fetch_data, 32'h0010_0093);
        check_mem("t1");

        // Same program with byte_valid toggling.
        step(1'b1, 2, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) step(1'b0, 0, 1'b1, prog[i / 2]);
            else            step(1'b0, 0, 1'b0, 8'hFF);
        end
        check_mem("t2");

        // Oversized request clamps to a full fill.
        step(1'b1, 20, 1'b0, 8'h00);
        for (int i = 0; i < 64; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        check_mem("t3");

        // Restart mid-word; the same-cycle byte is dropped.
        step(1'b1, 3, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        step(1'b1, 3, 1'b1, 8'hEE);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        check_mem("t4");

        // Reset in the middle of a word.
        step(1'b1, 4, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        apply_reset("t5");

        // Zero-length load after putting some content in memory.
        step(1'b1, 1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        step(1'b1, 0, 1'b1, 8'h55);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 8'($urandom));
        check_mem("t6");

        // Randomized traffic with occasional restarts.
        step(1'b1, int'($urandom_range(0, 31)), 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), int'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end
        check_mem("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
